// File: rtl/classifier_debounce.sv
// Debounces 1-bit classifier decisions: sliding-window majority vote with
// on/off hysteresis, a minimum on-time, and a single-entry output buffer.
module classifier_debounce #(
  parameter int unsigned WINDOW      = 8,
  parameter int unsigned ON_THRESH   = 5,
  parameter int unsigned OFF_THRESH  = 2,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic recv_rdy,
  input  logic recv_val,
  input  logic recv_msg,
  input  logic send_rdy,
  output logic send_val,
  output logic send_msg,
  output logic out_state
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  logic [WINDOW-1:0] hist_q, hist_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_next;
  logic [HW-1:0]     hold_q, hold_d;
  state_e            state_q, state_d;
  logic              sval_q, sval_d;
  logic              smsg_q, smsg_d;
  logic              out_q, out_d;
  logic              accept;

  // Upstream may push whenever the buffer is empty or is draining this edge
  assign recv_rdy = !sval_q || send_rdy;
  assign accept   = recv_val && recv_rdy;

  assign send_val  = sval_q;
  assign send_msg  = smsg_q;
  assign out_state = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      state_q <= ST_OFF;
      sval_q  <= 1'b0;
      smsg_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      sval_q  <= sval_d;
      smsg_q  <= smsg_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    state_d  = state_q;
    sval_d   = sval_q;
    smsg_d   = smsg_q;
    out_d    = out_q;
    cnt_next = cnt_q + CW'(recv_msg) - CW'(hist_q[WINDOW-1]);

    // Minimum on-time runs on clock cycles, not on accepted frames
    if (state_q == ST_ON && hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end

    if (accept) begin
      hist_d = WINDOW'({hist_q, recv_msg});
      cnt_d  = cnt_next;
      case (state_q)
        ST_OFF: begin
          if (cnt_next >= CW'(ON_THRESH)) begin
            state_d = ST_ON;
            hold_d  = HW'(HOLD_CYCLES);
          end
        end
        ST_ON: begin
          if (cnt_next <= CW'(OFF_THRESH) && hold_q == '0) begin
            state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
      sval_d = 1'b1;
      smsg_d = (state_d == ST_ON);
      out_d  = (state_d == ST_ON);
    end else if (send_rdy) begin
      sval_d = 1'b0;
    end
  end

endmodule
